// File: rtl/dqpsk_iq_mapper.sv
`default_nettype none
// ============================================================================
// Module   : dqpsk_iq_mapper
// Purpose  : Maps differentially-encoded DQPSK dibits onto signed I/Q
//            constellation points and upsamples them to SPS samples per
//            symbol, either by holding the point or by zero-stuffing.
//            Symbol-rate gaps (underruns) are flagged and counted.
// Revision : 1.0  initial release
// ============================================================================
module dqpsk_iq_mapper #(
  parameter int SPS        = 8,
  parameter int DW         = 12,
  parameter int AMP        = 1447,
  parameter int ZERO_STUFF = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           in_sym,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q,
  output logic                 out_valid,
  output logic                 sym_start,
  output logic                 underrun,
  output logic [15:0]          underrun_cnt
);

  // Counter wide enough for 0..SPS-1; SPS=1 still needs one bit.
  localparam int                     CW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0]          CNT_LAST = CW'(SPS - 1);
  localparam logic signed [DW-1:0]   POS      = DW'(AMP);
  localparam logic signed [DW-1:0]   NEG      = -POS;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic signed [DW-1:0] pt_i;
  logic signed [DW-1:0] pt_q;
  logic signed [DW-1:0] pt_i_nxt;
  logic signed [DW-1:0] pt_q_nxt;
  logic signed [DW-1:0] out_i_nxt;
  logic signed [DW-1:0] out_q_nxt;
  logic                 valid_nxt;
  logic                 start_nxt;
  logic                 sample_en;
  logic                 at_last;
  logic                 xfer;
  logic                 underrun_evt;

  // The last sample of a symbol is the only point where a new one can enter.
  assign at_last  = (state == ST_ACTIVE) && (cnt == CNT_LAST);
  assign in_ready = rstn && ((state == ST_IDLE) || at_last);
  assign xfer     = in_valid && in_ready;

  // State register, sample counter, held point and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pt_i      <= '0;
      pt_q      <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pt_i      <= pt_i_nxt;
      pt_q      <= pt_q_nxt;
      out_i     <= out_i_nxt;
      out_q     <= out_q_nxt;
      out_valid <= valid_nxt;
      sym_start <= start_nxt;
    end
  end

  // Next-state: walk the sample counter, reload or drop to IDLE at the end.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    underrun_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = '0;
        end
      end
      ST_ACTIVE: begin
        if (at_last) begin
          cnt_nxt = '0;
          if (!xfer) begin
            state_nxt    = ST_IDLE;
            underrun_evt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Decide which samples carry the point: all of them, or only the first.
  generate
    if (ZERO_STUFF != 0) begin : g_zero_stuff
      assign sample_en = start_nxt;
    end else begin : g_hold
      assign sample_en = valid_nxt;
    end
  endgenerate

  // Output decode: constellation lookup on transfer and next-cycle samples.
  always_comb begin
    pt_i_nxt = pt_i;
    pt_q_nxt = pt_q;
    if (xfer) begin
      // Bit 0 selects the I sign, bit 1 the Q sign (Gray-ordered quadrants).
      pt_i_nxt = in_sym[0] ? NEG : POS;
      pt_q_nxt = in_sym[1] ? NEG : POS;
    end
    valid_nxt = (state_nxt == ST_ACTIVE);
    start_nxt = valid_nxt && (cnt_nxt == '0);
    out_i_nxt = sample_en ? pt_i_nxt : '0;
    out_q_nxt = sample_en ? pt_q_nxt : '0;
  end

  // Sticky underrun flag and saturating event counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (underrun_evt) begin
      underrun <= 1'b1;
      if (underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dqpsk_iq_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_dqpsk_iq_mapper
// Purpose  : Scoreboard bench for dqpsk_iq_mapper. Three instances cover
//            SPS=8 hold, SPS=4 zero-stuff and SPS=1 configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_dqpsk_iq_mapper;

  localparam int AMP = 1447;

  typedef struct {
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic               ss;
    int                 due;
  } sb_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] a_sym, b_sym, c_sym;
  logic       a_valid, b_valid, c_valid;
  logic       a_ready, b_ready, c_ready;
  logic signed [11:0] a_i, a_q, b_i, b_q, c_i, c_q;
  logic       a_ov, b_ov, c_ov, a_ss, b_ss, c_ss, a_ur, b_ur, c_ur;
  logic [15:0] a_cnt, b_cnt, c_cnt;

  sb_t qa[$];
  sb_t qb[$];
  sb_t qc[$];

  dqpsk_iq_mapper #(.SPS(8), .DW(12), .AMP(AMP), .ZERO_STUFF(0)) u_a (
    .clk(clk), .rstn(rstn), .in_sym(a_sym), .in_valid(a_valid), .in_ready(a_ready),
    .out_i(a_i), .out_q(a_q), .out_valid(a_ov), .sym_start(a_ss),
    .underrun(a_ur), .underrun_cnt(a_cnt));

  dqpsk_iq_mapper #(.SPS(4), .DW(12), .AMP(AMP), .ZERO_STUFF(1)) u_b (
    .clk(clk), .rstn(rstn), .in_sym(b_sym), .in_valid(b_valid), .in_ready(b_ready),
    .out_i(b_i), .out_q(b_q), .out_valid(b_ov), .sym_start(b_ss),
    .underrun(b_ur), .underrun_cnt(b_cnt));

  dqpsk_iq_mapper #(.SPS(1), .DW(12), .AMP(AMP), .ZERO_STUFF(0)) u_c (
    .clk(clk), .rstn(rstn), .in_sym(c_sym), .in_valid(c_valid), .in_ready(c_ready),
    .out_i(c_i), .out_q(c_q), .out_valid(c_ov), .sym_start(c_ss),
    .underrun(c_ur), .underrun_cnt(c_cnt));

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string nm(input int w);
    return (w == 0) ? "A" : (w == 1) ? "B" : "C";
  endfunction

  function automatic int qsize(input int w);
    return (w == 0) ? qa.size() : (w == 1) ? qb.size() : qc.size();
  endfunction

  function automatic sb_t qfront(input int w);
    return (w == 0) ? qa[0] : (w == 1) ? qb[0] : qc[0];
  endfunction

  task automatic qpop(input int w);
    case (w)
      0:       void'(qa.pop_front());
      1:       void'(qb.pop_front());
      default: void'(qc.pop_front());
    endcase
  endtask

  task automatic qpush(input int w, input sb_t e);
    case (w)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? a_ready : (w == 1) ? b_ready : c_ready;
  endfunction

  task automatic drive(input int w, input logic [1:0] s, input logic v);
    case (w)
      0:       begin a_sym = s; a_valid = v; end
      1:       begin b_sym = s; b_valid = v; end
      default: begin c_sym = s; c_valid = v; end
    endcase
  endtask

  // Offer one symbol, wait for acceptance, and queue the samples it must produce.
  task automatic send(input int w, input logic [1:0] s, input int exp_wait);
    int k = 0;
    int sps;
    int zs;
    logic signed [11:0] pi, pq;
    sb_t e;
    sps = (w == 0) ? 8 : (w == 1) ? 4 : 1;
    zs  = (w == 1) ? 1 : 0;
    case (s)
      2'b00:   begin pi =  12'(AMP);  pq =  12'(AMP);  end
      2'b01:   begin pi = -12'(AMP);  pq =  12'(AMP);  end
      2'b11:   begin pi = -12'(AMP);  pq = -12'(AMP);  end
      default: begin pi =  12'(AMP);  pq = -12'(AMP);  end
    endcase
    drive(w, s, 1'b1);
    while (!rdy(w) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      check({nm(w), "_accept_timeout"}, k, 0);
    end else begin
      if (exp_wait >= 0) check({nm(w), "_ready_wait"}, k, exp_wait);
      for (int j = 0; j < sps; j++) begin
        e.i   = (zs != 0 && j != 0) ? 12'sd0 : pi;
        e.q   = (zs != 0 && j != 0) ? 12'sd0 : pq;
        e.ss  = (j == 0);
        e.due = cyc + 1 + j;
        qpush(w, e);
      end
      @(negedge clk);
    end
  endtask

  // Compare one instance's outputs against the scoreboard for this cycle.
  task automatic mon_step(input int w, input logic ov, input logic ss,
                          input logic signed [11:0] i, input logic signed [11:0] q);
    sb_t e;
    if (ov === 1'b1) begin
      if (qsize(w) == 0) begin
        check({nm(w), "_extra_sample"}, ov, 0);
      end else begin
        e = qfront(w);
        qpop(w);
        check({nm(w), "_due"}, cyc, e.due);
        check({nm(w), "_i"}, i, e.i);
        check({nm(w), "_q"}, q, e.q);
        check({nm(w), "_sym_start"}, ss, e.ss);
      end
    end else begin
      check({nm(w), "_idle_i"}, i, 0);
      check({nm(w), "_idle_q"}, q, 0);
      check({nm(w), "_idle_ss"}, ss, 0);
      if (qsize(w) > 0) begin
        e = qfront(w);
        if (e.due <= cyc) begin
          check({nm(w), "_late_valid"}, ov, 1);
          qpop(w);
        end
      end
    end
  endtask

  // Monitor all three instances away from the active edge.
  always @(negedge clk) begin
    mon_step(0, a_ov, a_ss, a_i, a_q);
    mon_step(1, b_ov, b_ss, b_i, b_q);
    mon_step(2, c_ov, c_ss, c_i, c_q);
  end

  // Stimulus sequence.
  initial begin
    rstn = 1'b0;
    drive(0, 2'b00, 1'b0);
    drive(1, 2'b00, 1'b0);
    drive(2, 2'b00, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_a_ov", a_ov, 0);
    check("rst_a_ur", a_ur, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ov", b_ov, 0);
    check("rst_c_cnt", c_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_a_ready", a_ready, 1);
    check("idle_a_ov", a_ov, 0);

    // Continuous stream at SPS=8, hold mode
    send(0, 2'b00, 0);
    send(0, 2'b01, 7);
    send(0, 2'b11, 7);
    send(0, 2'b10, 7);
    drive(0, 2'b10, 1'b0);
    check("stream_a_ur", a_ur, 0);
    repeat (20) @(negedge clk);
    check("stream_end_a_ur", a_ur, 1);
    check("stream_end_a_cnt", a_cnt, 1);

    // Reset in the middle of a symbol (cnt=3)
    send(0, 2'b01, 0);
    drive(0, 2'b01, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    while (qa.size() > 0 && qa[$].due > cyc) void'(qa.pop_back());
    @(negedge clk);
    @(negedge clk);
    check("midrst_a_ov", a_ov, 0);
    check("midrst_a_i", a_i, 0);
    check("midrst_a_q", a_q, 0);
    check("midrst_a_ur", a_ur, 0);
    check("midrst_a_cnt", a_cnt, 0);
    check("midrst_a_ready", a_ready, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst_a_ready", a_ready, 1);

    // Repeated underruns
    for (int g = 0; g < 4; g++) begin
      send(0, 2'($urandom_range(3)), 0);
      send(0, 2'($urandom_range(3)), 7);
      drive(0, 2'b00, 1'b0);
      repeat (20) @(negedge clk);
      check("gap_a_ur", a_ur, 1);
      check("gap_a_cnt", a_cnt, g + 1);
    end

    // Zero-stuffing at SPS=4
    send(1, 2'b11, 0);
    send(1, 2'b00, 3);
    drive(1, 2'b00, 1'b0);
    repeat (12) @(negedge clk);
    check("zs_b_ur", b_ur, 1);
    check("zs_b_cnt", b_cnt, 1);

    // SPS=1 one symbol per clock
    for (int n = 0; n < 10; n++) send(2, 2'($urandom_range(3)), 0);
    drive(2, 2'b00, 1'b0);
    repeat (5) @(negedge clk);
    check("sps1_c_cnt", c_cnt, 1);

    repeat (5) @(negedge clk);
    check("drain_A", qsize(0), 0);
    check("drain_B", qsize(1), 0);
    check("drain_C", qsize(2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dqpsk_iq_mapper.md
Name: dqpsk_iq_mapper

Overview:
- Sits directly downstream of the differential encoder in the DQPSK transmit chain.
- Accepts one differentially-encoded 2-bit symbol at a time over a valid/ready handshake and maps it to a signed I/Q constellation point.
- Holds each point for SPS clocks (rectangular upsampling), or emits it once followed by SPS-1 zeros (zero-stuffing), to feed the pulse-shaping filter.
- Flags and counts underruns, i.e. symbol-rate gaps.

Parameters:
- SPS, 8, samples per symbol; legal range 1..256.
- DW, 12, output sample width, signed two's complement.
- AMP, 1447, constellation magnitude per axis; must be ≤ 2^(DW-1)-1.
- ZERO_STUFF, 0, 0 = hold the point for SPS samples; 1 = point on the first sample, zero on the remaining SPS-1 samples.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- in_sym  in  2  encoded symbol from the differential encoder.
- in_valid  in  1  in_sym is valid.
- in_ready  out  1  mapper accepts in_sym this cycle.
- out_i  out  DW  in-phase sample, signed.
- out_q  out  DW  quadrature sample, signed.
- out_valid  out  1  out_i/out_q are valid this cycle.
- sym_start  out  1  high on the first sample of each symbol.
- underrun  out  1  sticky; set on an underrun, cleared only by reset.
- underrun_cnt  out  16  saturating count of underrun events.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State returns to IDLE and the sample counter to 0.
  - out_i=0, out_q=0, out_valid=0, sym_start=0, underrun=0, underrun_cnt=0.
  - in_ready=0 during the reset cycle.
  - Reset mid-symbol abandons the symbol immediately; nothing is flushed.
- Constellation, ±AMP on each axis:
  - 00 → (+AMP, +AMP), 45°
  - 01 → (−AMP, +AMP), 135°
  - 11 → (−AMP, −AMP), 225°
  - 10 → (+AMP, −AMP), 315°
  - −AMP is the exact two's-complement negation; no saturation is needed because AMP is in range.
- Handshake:
  - A transfer occurs when in_valid && in_ready at a clk edge.
  - in_ready is combinational: 1 in IDLE (out of reset); 1 in ACTIVE when cnt == SPS-1; otherwise 0.
  - in_valid with in_ready=0 is ignored. The upstream must hold in_sym until it is accepted.
- States:
  - IDLE: out_valid=0, outputs driven to 0.
    - Transfer → ACTIVE, cnt=0.
  - ACTIVE: out_valid=1, cnt advances 0..SPS-1 each clock.
    - At cnt == SPS-1 with a transfer → stay ACTIVE, cnt=0, load new point. Output is back-to-back with no bubble.
    - At cnt == SPS-1 with no transfer → IDLE, and one underrun event is recorded.
- Latency: a symbol transferred at edge t has its first sample on out_i/out_q with out_valid=1 and sym_start=1 in the cycle after edge t (registered outputs, 1-cycle latency).
- Sample values:
  - ZERO_STUFF=0: the point is held constant for SPS cycles.
  - ZERO_STUFF=1: the point appears on the cnt=0 sample; samples cnt=1..SPS-1 are 0, with out_valid still 1.
- sym_start: 1 exactly when out_valid=1 and cnt=0.
- Underrun:
  - Event = ACTIVE→IDLE transition only. The initial IDLE after reset is not an underrun.
  - underrun is set to 1 on the event.
  - underrun_cnt increments by 1 per event and saturates at 16'hFFFF without wrapping.
- SPS=1:
  - in_ready stays 1 while ACTIVE, so one symbol per clock is sustained.
  - Every sample has sym_start=1; ZERO_STUFF has no effect.
- Simultaneous events: reset dominates a transfer in the same cycle.

Test Plan:
- Reset, then continuous in_valid=1 with symbols 00,01,11,10 at SPS=8, ZERO_STUFF=0, AMP=1447:
  - Each point is held 8 cycles: (1447,1447), (−1447,1447), (−1447,−1447), (1447,−1447).
  - sym_start pulses every 8th cycle; in_ready is high only at cnt=7; no gaps; underrun=0.
- Latency check: a transfer at edge t must give out_valid=1 and sym_start=1 in cycle t+1; out_valid must be 0 in every cycle before it.
- Underrun: send 2 symbols, drop in_valid for 20 cycles, then resume:
  - out_valid falls after 16 samples; underrun=1; underrun_cnt=1.
  - On resume, in_ready is 1 in IDLE and output restarts with 1-cycle latency.
  - Repeat the gap 3 more times → underrun_cnt=4.
- ZERO_STUFF=1, SPS=4, symbol stream 11,00:
  - Samples are (−1447,−1447),0,0,0,(1447,1447),0,0,0.
  - out_valid=1 throughout.
- SPS=1: back-to-back symbols at one per clock:
  - in_ready stays 1 and sym_start stays 1.
  - The output sequence equals the input sequence delayed one cycle.
- Reset asserted at cnt=3 mid-symbol:
  - Next cycle all outputs are 0, out_valid=0 and underrun_cnt=0.
  - The held symbol is not re-emitted after reset releases.
